multi_delay_line: RTL and testbench

//  Parametrised multi-channel delay line with runtime-selectable latency and per-sample valid tracking.

---
 rtl/multi_delay_line.sv | 104 ++++++++++
 tb/tb_multi_delay_line.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multi_delay_line.sv
// Multi-channel delay line with a runtime-selectable latency (0..DEPTH) and a shared valid stream.
// Define MULTI_DELAY_LINE_STALL_EN to add the i_en stall input.
module multi_delay_line #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4,
  localparam int SELW    = $clog2(DEPTH + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
`ifdef MULTI_DELAY_LINE_STALL_EN
  input  logic                      i_en,
`endif
  input  logic [CHANNELS*WIDTH-1:0] i_d,
  input  logic                      i_valid,
  input  logic [SELW-1:0]           i_delay_sel,
  input  logic                      i_flush,
  output logic [CHANNELS*WIDTH-1:0] o_d,
  output logic                      o_valid
);

  logic             shift_en;
  logic [SELW-1:0]  eff_sel;
  logic [SELW-1:0]  sel_reg;
  logic             change;
  logic             drop;
  logic [DEPTH-1:0] vld_reg;
  logic [DEPTH-1:0] vld_next;
  logic             tap_v;

`ifdef MULTI_DELAY_LINE_STALL_EN
  assign shift_en = i_en;
`else
  assign shift_en = 1'b1;
`endif

  always_comb begin
    eff_sel = i_delay_sel;
    if (i_delay_sel > SELW'(DEPTH))
      eff_sel = SELW'(DEPTH);
  end

  assign change = (eff_sel != sel_reg);
  assign drop   = change | i_flush;

  // A change or flush discards everything in flight but keeps the sample entering this cycle.
  always_comb begin
    vld_next    = '0;
    vld_next[0] = i_valid;
    for (int k = 1; k < DEPTH; k++)
      vld_next[k] = vld_reg[k-1] & ~drop;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_reg <= '0;
      sel_reg <= '0;
    end else if (shift_en) begin
      vld_reg <= vld_next;
      sel_reg <= eff_sel;
    end
  end

  always_comb begin
    tap_v = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      if (eff_sel == SELW'(k + 1))
        tap_v = vld_reg[k];
  end

  always_comb begin
    if (eff_sel == '0)
      o_valid = i_valid & ~change;
    else
      o_valid = tap_v & ~change & shift_en;
  end

  // Data stages shift every enabled edge; only vld_reg decides whether a tap is meaningful.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic [WIDTH-1:0] stage_reg [DEPTH];
    logic [WIDTH-1:0] tap_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int k = 0; k < DEPTH; k++)
          stage_reg[k] <= '0;
      end else if (shift_en) begin
        stage_reg[0] <= i_d[gi*WIDTH +: WIDTH];
        for (int k = 1; k < DEPTH; k++)
          stage_reg[k] <= stage_reg[k-1];
      end
    end

    always_comb begin
      tap_d = i_d[gi*WIDTH +: WIDTH];
      for (int k = 0; k < DEPTH; k++)
        if (eff_sel == SELW'(k + 1))
          tap_d = stage_reg[k];
    end

    assign o_d[gi*WIDTH +: WIDTH] = tap_d;
  end

endmodule

// File: tb/tb_multi_delay_line.sv
// Directed bench for multi_delay_line (WIDTH=8, CHANNELS=2, DEPTH=4) with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_multi_delay_line;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [15:0] d = '0;
  logic        valid = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        flush = 1'b0;
  logic [15:0] q;
  logic        q_valid;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_delay_line #(.WIDTH(8), .CHANNELS(2), .DEPTH(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
`ifdef MULTI_DELAY_LINE_STALL_EN
    .i_en(en),
`endif
    .i_d(d),
    .i_valid(valid),
    .i_delay_sel(sel),
    .i_flush(flush),
    .o_d(q),
    .o_valid(q_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [2:0] s);
    sel = s; valid = 1'b0; flush = 1'b0; d = '0; en = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 3'd3;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom); valid = 1'($urandom);
      #1;
      checks++;
      if (q !== 16'h0) begin failures++; $display("FAIL reset_d cycle %0d got %h want 0000", i, q); end
      checks++;
      if (q_valid !== 1'b0) begin failures++; $display("FAIL reset_valid cycle %0d got %b want 0", i, q_valid); end
      tick();
    end
    rst = 1'b0;
    $display("reset: held 4 cycles at s=3");
  endtask

  task automatic test_latency();
    settle(3'd3);
    d = 16'hA55A; valid = 1'b1;
    #1;
    checks++;
    if (q_valid !== 1'b0) begin failures++; $display("FAIL latency_entry got %b want 0", q_valid); end
    tick();
    d = 16'h0; valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (q_valid !== (i == 3)) begin failures++; $display("FAIL latency_valid edge %0d got %b want %b", i, q_valid, (i == 3)); end
      if (i == 3) begin
        checks++;
        if (q !== 16'hA55A) begin failures++; $display("FAIL latency_data got %h want a55a", q); end
      end
      tick();
    end
    $display("latency: A55A at s=3");
  endtask

  task automatic test_passthrough_clamp();
    settle(3'd0);
    d = 16'h1234; valid = 1'b1;
    #1;
    checks++;
    if (q !== 16'h1234 || q_valid !== 1'b1) begin failures++; $display("FAIL passthrough got %h/%b want 1234/1", q, q_valid); end
    valid = 1'b0;
    #1;
    checks++;
    if (q_valid !== 1'b0) begin failures++; $display("FAIL passthrough_invalid got %b want 0", q_valid); end
    // Change cycle into sel=7: valid input must be suppressed.
    sel = 3'd7; valid = 1'b1;
    #1;
    checks++;
    if (q_valid !== 1'b0) begin failures++; $display("FAIL change_cycle_suppress got %b want 0", q_valid); end
    settle(3'd7);
    d = 16'hBEEF; valid = 1'b1;
    tick();
    d = 16'h0; valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (q_valid !== (i == 4)) begin failures++; $display("FAIL clamp_valid edge %0d got %b want %b", i, q_valid, (i == 4)); end
      if (i == 4) begin
        checks++;
        if (q !== 16'hBEEF) begin failures++; $display("FAIL clamp_data got %h want beef", q); end
      end
      tick();
    end
    $display("passthrough: 1234 at s=0, BEEF at sel=7 clamped to 4");
  endtask

  task automatic test_delay_change();
    logic       exp_v [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
    logic [7:0] exp_n [10] = '{0, 0, 0, 0, 1, 2, 0, 0, 7, 8};
    settle(3'd4);
    for (int c = 0; c < 10; c++) begin
      sel = (c < 6) ? 3'd4 : 3'd2;
      d = {8'(c + 1), 8'(c + 1)}; valid = 1'b1;
      #1;
      checks++;
      if (q_valid !== exp_v[c]) begin failures++; $display("FAIL change_valid cycle %0d got %b want %b", c, q_valid, exp_v[c]); end
      if (exp_v[c]) begin
        checks++;
        if (q !== {exp_n[c], exp_n[c]}) begin failures++; $display("FAIL change_data cycle %0d got %h want %h", c, q, {exp_n[c], exp_n[c]}); end
      end
      tick();
    end
    valid = 1'b0;
    $display("delay_change: s=4 -> s=2 at cycle 6");
  endtask

  task automatic test_flush();
    settle(3'd4);
    for (int c = 0; c < 10; c++) begin
      flush = (c == 4);
      valid = (c <= 4);
      d = (c < 4) ? {2{8'(8'h11 * (c + 1))}} : (c == 4) ? 16'h7777 : 16'h0;
      #1;
      checks++;
      if (q_valid !== (c == 4 || c == 8)) begin failures++; $display("FAIL flush_valid cycle %0d got %b want %b", c, q_valid, (c == 4 || c == 8)); end
      if (c == 4) begin
        checks++;
        if (q !== 16'h1111) begin failures++; $display("FAIL flush_cycle_data got %h want 1111", q); end
      end
      if (c == 8) begin
        checks++;
        if (q !== 16'h7777) begin failures++; $display("FAIL flush_new_data got %h want 7777", q); end
      end
      tick();
    end
    flush = 1'b0; valid = 1'b0;
    $display("flush: only 7777 survives at s=4");
  endtask

`ifdef MULTI_DELAY_LINE_STALL_EN
  task automatic test_stall();
    settle(3'd2);
    d = 16'h5A5A; valid = 1'b1;
    tick();
    d = 16'h0; valid = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (q_valid !== 1'b0) begin failures++; $display("FAIL stall_valid cycle %0d got %b want 0", i, q_valid); end
      tick();
    end
    en = 1'b1;
    #1;
    checks++;
    if (q_valid !== 1'b0) begin failures++; $display("FAIL stall_release got %b want 0", q_valid); end
    tick();
    checks++;
    if (q_valid !== 1'b1 || q !== 16'h5A5A) begin failures++; $display("FAIL stall_emerge got %h/%b want 5a5a/1", q, q_valid); end
    $display("stall: 5A5A held 5 cycles at s=2");
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_passthrough_clamp();
    test_delay_change();
    test_flush();
`ifdef MULTI_DELAY_LINE_STALL_EN
    test_stall();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
